// File: rtl/bp_be_fe_queue_buffer_pkg.sv
// Shared types for the BE-side fetch-packet queue: packet layout, packet
// enums and the pointer-width helper.
package bp_be_fe_queue_buffer_pkg;

  localparam int unsigned vaddr_width_lp           = 39;
  localparam int unsigned instr_width_lp           = 32;
  localparam int unsigned branch_metadata_width_lp = 36;

  typedef enum logic [1:0] {
    e_fe_fetch     = 2'd0,
    e_fe_exception = 2'd1
  } bp_fe_queue_type_e;

  typedef enum logic [2:0] {
    e_itlb_miss          = 3'd0,
    e_instr_page_fault   = 3'd1,
    e_instr_access_fault = 3'd2,
    e_icache_miss        = 3'd3,
    e_exc_none           = 3'd7
  } bp_fe_exception_code_e;

  typedef struct packed {
    bp_fe_queue_type_e                   msg_type;
    bp_fe_exception_code_e               exception_code;
    logic [vaddr_width_lp-1:0]           vaddr;
    logic [instr_width_lp-1:0]           instr;
    logic [branch_metadata_width_lp-1:0] branch_metadata_fwd;
  } bp_fe_queue_s;

  localparam int unsigned fe_queue_width_lp = $bits(bp_fe_queue_s);

  // Index bits plus one wrap bit.
  function automatic int unsigned bp_be_fe_queue_ptr_width(input int unsigned els);
    return $clog2(els) + 1;
  endfunction

endpackage

// File: rtl/bp_be_fe_queue_buffer_if.sv
// FE-to-BE queue handshake bundle: enqueue side, read side and the
// commit/roll/clear controls.
interface bp_be_fe_queue_buffer_if;
  import bp_be_fe_queue_buffer_pkg::*;

  bp_fe_queue_s fe_queue_i;
  logic         fe_queue_v_i;
  logic         fe_queue_ready_and_o;
  bp_fe_queue_s fe_queue_o;
  logic         fe_queue_v_o;
  logic         fe_queue_yumi_i;
  logic         deq_v_i;
  logic         roll_v_i;
  logic         clr_v_i;
  logic         empty_o;

  modport slave (
    input  fe_queue_i, fe_queue_v_i, fe_queue_yumi_i, deq_v_i, roll_v_i, clr_v_i,
    output fe_queue_ready_and_o, fe_queue_o, fe_queue_v_o, empty_o
  );

  modport master (
    output fe_queue_i, fe_queue_v_i, fe_queue_yumi_i, deq_v_i, roll_v_i, clr_v_i,
    input  fe_queue_ready_and_o, fe_queue_o, fe_queue_v_o, empty_o
  );

endinterface

// File: rtl/bp_be_fe_queue_buffer_mem.sv
// 1-read 1-write register-file storage: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module bp_be_fe_queue_buffer_mem #(
  parameter int unsigned width_p = 8,
  parameter int unsigned els_p   = 8
) (
  input  logic                       clk_i,
  input  logic                       w_v_i,
  input  logic [$clog2(els_p)-1:0]   w_addr_i,
  input  logic [width_p-1:0]         w_data_i,
  input  logic [$clog2(els_p)-1:0]   r_addr_i,
  output logic [width_p-1:0]         r_data_o
);

  logic [width_p-1:0] mem_q [els_p];

  always_ff @(posedge clk_i) begin
    if (w_v_i) begin
      mem_q[w_addr_i] <= w_data_i;
    end
  end

  assign r_data_o = mem_q[r_addr_i];

endmodule

// File: rtl/bp_be_fe_queue_buffer.sv
// Checkpointed circular fetch-packet queue: entries stay resident after being
// read until committed (deq), so the BE can rewind (roll) or flush (clr).
module bp_be_fe_queue_buffer
  import bp_be_fe_queue_buffer_pkg::*;
#(
  parameter int unsigned els_p = 8
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  bp_be_fe_queue_buffer_if.slave  fe_if
);

  localparam int unsigned ptr_w_lp = bp_be_fe_queue_ptr_width(els_p);
  localparam int unsigned idx_w_lp = ptr_w_lp - 1;

  typedef logic [ptr_w_lp-1:0] ptr_t;

  ptr_t cptr_q, cptr_d;
  ptr_t rptr_q, rptr_d;
  ptr_t wptr_q, wptr_d;
  logic v_q, v_d;
  logic ready_q, ready_d;
  logic empty_q, empty_d;

  logic enq, yumi, deq, roll, clr, wr_v;
  logic [fe_queue_width_lp-1:0] rd_data;

  // Full when indices match but the wrap bits disagree.
  function automatic logic is_full(input ptr_t c, input ptr_t w);
    return (c[idx_w_lp-1:0] == w[idx_w_lp-1:0]) && (c[ptr_w_lp-1] != w[ptr_w_lp-1]);
  endfunction

  always_comb begin
    enq  = fe_if.fe_queue_v_i & ready_q;
    yumi = fe_if.fe_queue_yumi_i & v_q;
    deq  = fe_if.deq_v_i & (cptr_q != rptr_q);
    roll = fe_if.roll_v_i;
    clr  = fe_if.clr_v_i;
    // A packet accepted during a redirect is acknowledged but not stored.
    wr_v = enq & ~clr;

    cptr_d = cptr_q + ptr_w_lp'(deq);
    rptr_d = roll ? cptr_d : (rptr_q + ptr_w_lp'(yumi));
    wptr_d = clr ? rptr_d : (wptr_q + ptr_w_lp'(wr_v));

    v_d     = (rptr_d != wptr_d);
    ready_d = ~is_full(cptr_d, wptr_d);
    empty_d = (cptr_d == wptr_d);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cptr_q  <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
      v_q     <= 1'b0;
      ready_q <= 1'b1;
      empty_q <= 1'b1;
    end else begin
      cptr_q  <= cptr_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      v_q     <= v_d;
      ready_q <= ready_d;
      empty_q <= empty_d;
    end
  end

  bp_be_fe_queue_buffer_mem #(
    .width_p (fe_queue_width_lp),
    .els_p   (els_p)
  ) u_mem (
    .clk_i    (clk_i),
    .w_v_i    (wr_v & ~reset_i),
    .w_addr_i (wptr_q[idx_w_lp-1:0]),
    .w_data_i (fe_if.fe_queue_i),
    .r_addr_i (rptr_q[idx_w_lp-1:0]),
    .r_data_o (rd_data)
  );

  assign fe_if.fe_queue_o           = bp_fe_queue_s'(rd_data);
  assign fe_if.fe_queue_v_o         = v_q;
  assign fe_if.fe_queue_ready_and_o = ready_q;
  assign fe_if.empty_o              = empty_q;

  // Protocol checks on the BE-side controls.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(fe_if.fe_queue_yumi_i && !v_q))
        else $error("fe_queue: yumi while no valid entry");
      assert (!(fe_if.deq_v_i && (cptr_q == rptr_q)))
        else $error("fe_queue: deq with no read-but-uncommitted entry");
      assert (!(enq && is_full(cptr_q, wptr_q)))
        else $error("fe_queue: enqueue while full");
    end
  end

endmodule

// File: tb/tb_bp_be_fe_queue_buffer.sv
// Directed bench for the 4-entry fetch queue; read data is scoreboarded
// against expected packets queued when each yumi is issued.
module tb_bp_be_fe_queue_buffer;
  import bp_be_fe_queue_buffer_pkg::*;

  logic clk;
  logic reset_i;
  int   checks   = 0;
  int   failures = 0;

  bp_fe_queue_s exp_q[$];

  bp_be_fe_queue_buffer_if fe_if ();

  bp_be_fe_queue_buffer #(.els_p(4)) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .fe_if   (fe_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, timeout reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic bp_fe_queue_s pkt(input int n);
    bp_fe_queue_s p;
    p.msg_type            = (n % 5 == 3) ? e_fe_exception : e_fe_fetch;
    p.exception_code      = (n % 5 == 3) ? e_icache_miss : e_exc_none;
    p.vaddr               = 39'(32'h8000_0000 + n * 4);
    p.instr               = 32'(n) ^ 32'hA5A5_0000;
    p.branch_metadata_fwd = 36'(n * 3 + 1);
    return p;
  endfunction

  // Scoreboard monitor: every consumed output is popped and compared.
  always @(negedge clk) begin
    if (!reset_i && fe_if.fe_queue_yumi_i) begin
      checks++;
      if (!fe_if.fe_queue_v_o) begin
        failures++;
        $display("FAIL rd_valid: actual v_o=0 required v_o=1 at yumi");
      end else if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rd_extra: actual %h required none (scoreboard empty)", fe_if.fe_queue_o);
      end else begin
        bp_fe_queue_s e;
        e = exp_q.pop_front();
        if (fe_if.fe_queue_o !== e) begin
          failures++;
          $display("FAIL rd_data: actual %h required %h", fe_if.fe_queue_o, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    fe_if.fe_queue_v_i    = 1'b0;
    fe_if.fe_queue_yumi_i = 1'b0;
    fe_if.deq_v_i         = 1'b0;
    fe_if.roll_v_i        = 1'b0;
    fe_if.clr_v_i         = 1'b0;
  endtask

  task automatic enq(input int n);
    fe_if.fe_queue_v_i = 1'b1;
    fe_if.fe_queue_i   = pkt(n);
    step();
  endtask

  task automatic rd(input int n);
    fe_if.fe_queue_yumi_i = 1'b1;
    exp_q.push_back(pkt(n));
    step();
  endtask

  task automatic deqn(input int k);
    repeat (k) begin
      fe_if.deq_v_i = 1'b1;
      step();
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual %b required %b", name, act, exp);
    end
  endtask

  task automatic check_status(input string name, input logic v, input logic r, input logic e);
    check_bit({name, ".v_o"},     fe_if.fe_queue_v_o,         v);
    check_bit({name, ".ready_o"}, fe_if.fe_queue_ready_and_o, r);
    check_bit({name, ".empty_o"}, fe_if.empty_o,              e);
  endtask

  initial begin
    fe_if.fe_queue_i      = '0;
    fe_if.fe_queue_v_i    = 1'b0;
    fe_if.fe_queue_yumi_i = 1'b0;
    fe_if.deq_v_i         = 1'b0;
    fe_if.roll_v_i        = 1'b0;
    fe_if.clr_v_i         = 1'b0;
    reset_i               = 1'b1;
    step();
    step();
    reset_i = 1'b0;
    check_status("reset", 1'b0, 1'b1, 1'b1);

    // 1: fill, drain, commit one slot to reopen
    enq(10);
    check_status("t1_first_enq", 1'b1, 1'b1, 1'b0);
    enq(11);
    enq(12);
    enq(13);
    check_status("t1_full", 1'b1, 1'b0, 1'b0);
    rd(10); rd(11); rd(12); rd(13);
    check_status("t1_all_read", 1'b0, 1'b0, 1'b0);
    deqn(1);
    check_status("t1_deq_reopen", 1'b0, 1'b1, 1'b0);
    deqn(3);
    check_status("t1_drained", 1'b0, 1'b1, 1'b1);

    // 2: roll replays uncommitted reads
    enq(20); enq(21);
    rd(20); rd(21);
    check_status("t2_read", 1'b0, 1'b1, 1'b0);
    fe_if.roll_v_i = 1'b1;
    step();
    check_status("t2_roll", 1'b1, 1'b1, 1'b0);
    rd(20); rd(21);
    deqn(2);
    check_status("t2_done", 1'b0, 1'b1, 1'b1);

    // 3: clr drops unread entries and a same-cycle enqueue
    enq(30); enq(31); enq(32);
    rd(30);
    check_bit("t3_ready_at_clr", fe_if.fe_queue_ready_and_o, 1'b1);
    fe_if.clr_v_i      = 1'b1;
    fe_if.fe_queue_v_i = 1'b1;
    fe_if.fe_queue_i   = pkt(33);
    step();
    check_status("t3_clr", 1'b0, 1'b1, 1'b0);
    fe_if.roll_v_i = 1'b1;
    step();
    check_status("t3_roll", 1'b1, 1'b1, 1'b0);
    rd(30);
    check_status("t3_only_a", 1'b0, 1'b1, 1'b0);
    deqn(1);
    check_status("t3_done", 1'b0, 1'b1, 1'b1);

    // 4: six full rounds through the wrap boundary
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 4; k++) begin
        enq(r * 4 + k);
        check_bit("t4_ready", fe_if.fe_queue_ready_and_o, (k < 3) ? 1'b1 : 1'b0);
        check_bit("t4_empty", fe_if.empty_o, 1'b0);
      end
      for (int k = 0; k < 4; k++) rd(r * 4 + k);
      deqn(4);
      check_status("t4_round_empty", 1'b0, 1'b1, 1'b1);
    end

    // 5: deq+roll+yumi together: roll wins over yumi, lands on new commit point
    enq(40); enq(41); enq(42);
    rd(40); rd(41);
    fe_if.deq_v_i  = 1'b1;
    fe_if.roll_v_i = 1'b1;
    rd(42);
    check_status("t5_combo", 1'b1, 1'b1, 1'b0);
    rd(41); rd(42);
    check_status("t5_read_out", 1'b0, 1'b1, 1'b0);
    deqn(2);
    check_status("t5_done", 1'b0, 1'b1, 1'b1);

    // 6: reset with entries held; enqueue during reset is ignored
    enq(50); enq(51); enq(52);
    reset_i            = 1'b1;
    fe_if.fe_queue_v_i = 1'b1;
    fe_if.fe_queue_i   = pkt(59);
    step();
    reset_i = 1'b0;
    check_status("t6_reset", 1'b0, 1'b1, 1'b1);
    enq(60); enq(61); enq(62); enq(63);
    check_status("t6_full", 1'b1, 1'b0, 1'b0);
    rd(60); rd(61); rd(62); rd(63);
    deqn(4);
    check_status("t6_done", 1'b0, 1'b1, 1'b1);

    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: actual %0d pending required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
